rmap_wb_arbiter: RTL and testbench

- Two-master Wishbone arbiter; shares the single Wishbone slave bus between the RMAP target (master 0) and a local host/CPU port (master 1).
- Round-robin arbitration at cycle granularity: a grant is held for the whole cyc window, so RMAP read-modify-write stays atomic.
- Built-in bus watchdog: a slave that never answers causes an injected err to the owner, so the RMAP target can report an error reply instead of hanging.

---
 rtl/rmap_wb_arbiter.sv | 96 +++++++++
 tb/tb_rmap_wb_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rmap_wb_arbiter.sv
// rmap_wb_arbiter: two-master round-robin Wishbone arbiter with cycle-granular grants
// and a bus watchdog that injects err to the owner when the slave never answers.
module rmap_wb_arbiter #(
   parameter int BUS_WIDTH = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   m0CycIn,
   input  logic                   m0StbIn,
   input  logic                   m0WeIn,
   input  logic [31:0]            m0AdrIn,
   input  logic [BUS_WIDTH/8-1:0] m0SelIn,
   input  logic [BUS_WIDTH-1:0]   m0DatIn,
   output logic [BUS_WIDTH-1:0]   m0DatOut,
   output logic                   m0AckOut,
   output logic                   m0ErrOut,
   input  logic                   m1CycIn,
   input  logic                   m1StbIn,
   input  logic                   m1WeIn,
   input  logic [31:0]            m1AdrIn,
   input  logic [BUS_WIDTH/8-1:0] m1SelIn,
   input  logic [BUS_WIDTH-1:0]   m1DatIn,
   output logic [BUS_WIDTH-1:0]   m1DatOut,
   output logic                   m1AckOut,
   output logic                   m1ErrOut,
   output logic                   cycOut,
   output logic                   stbOut,
   output logic                   weOut,
   output logic [31:0]            adrOut,
   output logic [BUS_WIDTH/8-1:0] selOut,
   output logic [BUS_WIDTH-1:0]   datOut,
   input  logic [BUS_WIDTH-1:0]   datIn,
   input  logic                   ackIn,
   input  logic                   errIn,
   output logic [1:0]             grant,
   output logic                   timeoutEvent
);
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t          r_state, w_next;
   logic            r_last;
   logic [CW-1:0]   r_cnt;
   logic            r_to;
   logic            w_own0, w_own1, w_own, w_cyc, w_stb, w_fire;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;

   // A tie goes to whichever master did not own the bus last.
   always_comb
      w_next = (r_state == IDLE) ?
               ((m0CycIn && m1CycIn) ? (r_last ? OWN0 : OWN1) :
                m0CycIn ? OWN0 : m1CycIn ? OWN1 : IDLE) :
               (w_cyc ? r_state : IDLE);

   always_comb begin
      w_own0       = r_state == OWN0;
      w_own1       = r_state == OWN1;
      w_own        = w_own0 | w_own1;
      w_cyc        = w_own0 ? m0CycIn : w_own1 & m1CycIn;
      w_stb        = w_own0 ? m0StbIn : w_own1 & m1StbIn;
      w_fire       = TIMEOUT != 0 && w_own && w_cyc && w_stb && !ackIn && !errIn &&
                     !r_to && r_cnt == CW'(TIMEOUT);
      grant        = {w_own1, w_own0};
      cycOut       = w_cyc;
      stbOut       = w_stb & ~r_to;
      weOut        = w_own0 ? m0WeIn : w_own1 & m1WeIn;
      adrOut       = w_own0 ? m0AdrIn : w_own1 ? m1AdrIn : '0;
      selOut       = w_own0 ? m0SelIn : w_own1 ? m1SelIn : '0;
      datOut       = w_own0 ? m0DatIn : w_own1 ? m1DatIn : '0;
      m0AckOut     = w_own0 & ackIn;
      m0ErrOut     = w_own0 & (errIn | r_to);
      m0DatOut     = w_own0 ? datIn : '0;
      m1AckOut     = w_own1 & ackIn;
      m1ErrOut     = w_own1 & (errIn | r_to);
      m1DatOut     = w_own1 ? datIn : '0;
      timeoutEvent = r_to;
   end

   // The injected-err cycle also suppresses stb, so the counter restarts from zero afterwards.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_last <= 1'b1;
         r_cnt  <= '0;
         r_to   <= 1'b0;
      end else begin
         if (w_own && !w_cyc) r_last <= w_own1;
         r_to  <= w_fire;
         r_cnt <= (!w_own || !w_cyc || !w_stb || ackIn || errIn || r_to || w_fire || TIMEOUT == 0) ?
                  '0 : r_cnt + CW'(1);
      end
endmodule

// File: tb/tb_rmap_wb_arbiter.sv
// tb_rmap_wb_arbiter: directed test-plan sequences plus random traffic, every cycle
// compared against a behavioural arbiter model.
module tb_rmap_wb_arbiter;
   localparam int TO = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        m_cyc [2];
   logic        m_stb [2];
   logic        m_we  [2];
   logic [31:0] m_adr [2];
   logic [3:0]  m_sel [2];
   logic [31:0] m_dat [2];
   logic [31:0] datIn;
   logic        ackIn, errIn;

   logic [31:0] m0DatOut, m1DatOut, adrOut, datOut;
   logic        m0AckOut, m0ErrOut, m1AckOut, m1ErrOut;
   logic        cycOut, stbOut, weOut, timeoutEvent;
   logic [3:0]  selOut;
   logic [1:0]  grant;

   int n_vec = 0;
   int n_err = 0;
   int own, last, wcnt;
   bit fire;

   always #5 clk = ~clk;

   rmap_wb_arbiter #(.BUS_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m0CycIn(m_cyc[0]), .m0StbIn(m_stb[0]), .m0WeIn(m_we[0]), .m0AdrIn(m_adr[0]),
      .m0SelIn(m_sel[0]), .m0DatIn(m_dat[0]), .m0DatOut(m0DatOut), .m0AckOut(m0AckOut),
      .m0ErrOut(m0ErrOut),
      .m1CycIn(m_cyc[1]), .m1StbIn(m_stb[1]), .m1WeIn(m_we[1]), .m1AdrIn(m_adr[1]),
      .m1SelIn(m_sel[1]), .m1DatIn(m_dat[1]), .m1DatOut(m1DatOut), .m1AckOut(m1AckOut),
      .m1ErrOut(m1ErrOut),
      .cycOut(cycOut), .stbOut(stbOut), .weOut(weOut), .adrOut(adrOut), .selOut(selOut),
      .datOut(datOut), .datIn(datIn), .ackIn(ackIn), .errIn(errIn), .grant(grant),
      .timeoutEvent(timeoutEvent)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic mreset();
      own = -1; last = 1; wcnt = 0; fire = 0;
   endtask

   // Arbiter behaviour at a clock edge, from the inputs present just before it.
   task automatic mupd();
      bit nf;
      if (own < 0) begin
         if (m_cyc[0] && m_cyc[1]) own = (last == 0) ? 1 : 0;
         else if (m_cyc[0]) own = 0;
         else if (m_cyc[1]) own = 1;
         wcnt = 0; fire = 0;
      end else if (!m_cyc[own]) begin
         last = own; own = -1; wcnt = 0; fire = 0;
      end else begin
         nf   = !fire && m_stb[own] && !ackIn && !errIn && wcnt == TO;
         wcnt = (nf || fire || !m_stb[own] || ackIn || errIn) ? 0 : wcnt + 1;
         fire = nf;
      end
   endtask

   task automatic compare();
      logic [70:0] e_bus;
      logic [33:0] e_r0, e_r1;
      e_bus = (own >= 0) ? {m_cyc[own], m_stb[own] & ~fire, m_we[own], m_adr[own], m_sel[own], m_dat[own]} : '0;
      e_r0  = (own == 0) ? {ackIn, errIn | fire, datIn} : '0;
      e_r1  = (own == 1) ? {ackIn, errIn | fire, datIn} : '0;
      chk("grant", grant, (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00);
      chk("slave_bus", {cycOut, stbOut, weOut, adrOut, selOut, datOut}, e_bus);
      chk("m0_resp", {m0AckOut, m0ErrOut, m0DatOut}, e_r0);
      chk("m1_resp", {m1AckOut, m1ErrOut, m1DatOut}, e_r1);
      chk("timeout_event", timeoutEvent, fire);
   endtask

   // Entered at posedge+1 with inputs set; returns at the next posedge+1.
   task automatic step();
      #1;
      if (rst) mreset();
      compare();
      @(posedge clk);
      if (rst) mreset(); else mupd();
      #1;
   endtask

   task automatic idle_all();
      for (int i = 0; i < 2; i++) begin
         m_cyc[i] = 0; m_stb[i] = 0; m_we[i] = 0;
      end
      ackIn = 0; errIn = 0;
   endtask

   task automatic do_reset();
      idle_all();
      rst = 1; step();
      rst = 0; step();
   endtask

   initial begin
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         m_adr[i] = 0; m_sel[i] = 0; m_dat[i] = 0;
      end
      idle_all(); datIn = 0;
      mreset();
      @(posedge clk); #1;
      #1;
      chk("reset_state", {grant, cycOut, stbOut, m0AckOut, m1AckOut, timeoutEvent}, 7'b0);
      do_reset();

      // m0 write, slave acks on the third owned cycle
      m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1; m_adr[0] = 32'h4; m_dat[0] = 32'h89ABCDEF; m_sel[0] = 4'hF;
      step(); step(); step();
      ackIn = 1;
      #1; chk("wr_adr_dat", {grant, adrOut, datOut, m0AckOut, m1AckOut}, {2'b01, 32'h4, 32'h89ABCDEF, 2'b10});
      step();
      ackIn = 0; m_cyc[0] = 0; m_stb[0] = 0;
      step(); step();

      // tie after reset -> m0, then one idle cycle, then m1; second tie -> m0
      do_reset();
      m_cyc[0] = 1; m_cyc[1] = 1;
      step();
      #1; chk("tie_first", grant, 2'b01);
      step();
      m_cyc[0] = 0;
      step();
      #1; chk("gap_idle", grant, 2'b00);
      step();
      #1; chk("tie_second_owner", grant, 2'b10);
      m_cyc[0] = 1;
      step();
      m_cyc[1] = 0;
      step();
      #1; chk("tie_alternate", grant, 2'b00);
      step();
      #1; chk("tie_back_to_m0", grant, 2'b01);
      m_cyc[0] = 0; step(); step();

      // m0 read then write in one cyc window while m1 keeps requesting
      do_reset();
      m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 0; m_adr[0] = 0; m_cyc[1] = 1; m_stb[1] = 1;
      step(); step();
      ackIn = 1; datIn = 32'h12345678;
      #1; chk("rd_data", {m0AckOut, m0DatOut, m1AckOut}, {1'b1, 32'h12345678, 1'b0});
      step();
      ackIn = 0; m_stb[0] = 0; step();
      m_stb[0] = 1; m_we[0] = 1; m_adr[0] = 32'h8; step();
      ackIn = 1;
      #1; chk("rmw_hold", {grant, adrOut}, {2'b01, 32'h8});
      step();
      ackIn = 0; m_cyc[0] = 0; m_stb[0] = 0;
      step(); step();
      #1; chk("rmw_then_m1", grant, 2'b10);
      m_cyc[1] = 0; m_stb[1] = 0; step(); step();

      // watchdog fires 256 cycles after m1's strobe reaches the slave
      m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 0;
      step();
      for (int i = 0; i < 256; i++) step();
      #1; chk("wd_fire", {m1ErrOut, timeoutEvent, stbOut}, 3'b110);
      step();
      #1; chk("wd_one_pulse", {m1ErrOut, timeoutEvent, stbOut}, 3'b001);
      ackIn = 1; step();
      ackIn = 0; m_cyc[1] = 0; m_stb[1] = 0; step(); step();

      // async reset while m1 owns with stb high
      m_cyc[1] = 1; m_stb[1] = 1;
      step(); step();
      rst = 1;
      #1; chk("async_rst", {cycOut, stbOut, grant}, 4'b0);
      step();
      rst = 0;
      m_cyc[0] = 1; m_cyc[1] = 1; m_stb[1] = 0;
      step();
      #1; chk("rst_tie_m0", grant, 2'b01);
      m_cyc[0] = 0; m_cyc[1] = 0; step(); step();

      // ack lands in the same cycle the counter reaches TIMEOUT: ack wins
      m_cyc[0] = 1; m_stb[0] = 1;
      step();
      for (int i = 0; i < TO; i++) step();
      ackIn = 1;
      #1; chk("ack_vs_wd", {m0AckOut, m0ErrOut}, 2'b10);
      step();
      ackIn = 0;
      #1; chk("ack_vs_wd_noerr", {m0ErrOut, timeoutEvent}, 2'b00);
      m_cyc[0] = 0; m_stb[0] = 0; step(); step();

      // random traffic from both masters
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(7) == 0) m_cyc[i] = ~m_cyc[i];
            m_stb[i] = m_cyc[i] & 1'($urandom_range(1));
            m_we[i]  = 1'($urandom_range(1));
            m_adr[i] = $urandom;
            m_sel[i] = 4'($urandom_range(15));
            m_dat[i] = $urandom;
         end
         ackIn = ($urandom_range(3) == 0);
         errIn = ($urandom_range(15) == 0);
         datIn = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
